// File: rtl/mult_sched_pkg.sv
// ---------------------------------------------------------------------------
// mult_sched_pkg
// Shared constants and elaboration-time helpers for the multiplier scheduler:
//   bit_width()    - number of bits needed to represent a non-negative value
//   mult_latency() - pipeline depth of the shared multiplier for given widths
//   id_width()     - width of a requester index, never below one bit
//   MULT_LAT_10X10 - latency of the default 10x10 configuration (4)
// ---------------------------------------------------------------------------
package mult_sched_pkg;

    function automatic int bit_width(input int v);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((v >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic int mult_latency(input int a_w, input int b_w);
        int m;
        int bw;
        m  = (a_w < b_w) ? a_w : b_w;
        bw = bit_width(m - 1);
        return (bw > 1) ? bw : 1;
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int MULT_LAT_10X10 = mult_latency(10, 10);

endpackage

// File: rtl/mult_pipe.sv
// ---------------------------------------------------------------------------
// mult_pipe
// Generic stallable unsigned pipelined multiplier. The product of a_i*b_i
// appears on p_o LATENCY enabled clocks after the operands are presented.
// While stall_i is high every stage holds its contents.
// Ports:
//   clk_i       clock, rising edge
//   reset_an_i  synchronous active-low reset (clears all stages)
//   reset_i     synchronous active-high reset (clears all stages)
//   stall_i     hold all stages
//   a_i, b_i    unsigned operands
//   p_o         unsigned product, A_WIDTH+B_WIDTH bits
// ---------------------------------------------------------------------------
module mult_pipe #(
    parameter int A_WIDTH = 10,
    parameter int B_WIDTH = 10,
    parameter int LATENCY = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_an_i,
    input  logic                       reset_i,
    input  logic                       stall_i,
    input  logic [A_WIDTH-1:0]         a_i,
    input  logic [B_WIDTH-1:0]         b_i,
    output logic [A_WIDTH+B_WIDTH-1:0] p_o
);

    localparam int P_W = A_WIDTH + B_WIDTH;

    logic [P_W-1:0] r_p [LATENCY];

    always_ff @(posedge clk_i) begin
        if (!reset_an_i || reset_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_p[i] <= '0;
            end
        end else if (!stall_i) begin
            // stage 0: full product, later stages only delay it
            r_p[0] <= P_W'(a_i) * P_W'(b_i);
            for (int i = 1; i < LATENCY; i++) begin
                r_p[i] <= r_p[i-1];
            end
        end
    end

    assign p_o = r_p[LATENCY-1];

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns a one-hot grant for the first
// asserted request found when searching upward from ptr_i and wrapping.
// Ports:
//   req_i  request vector
//   ptr_i  index with highest priority this cycle
//   gnt_o  one-hot grant, zero when no request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    logic w_found;

    always_comb begin
        gnt_o   = '0;
        w_found = 1'b0;
        // indices at or above the pointer first, then wrap to the bottom
        for (int j = 0; j < N; j++) begin
            if (!w_found && (j >= int'(ptr_i)) && req_i[j]) begin
                gnt_o[j] = 1'b1;
                w_found  = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!w_found && (j < int'(ptr_i)) && req_i[j]) begin
                gnt_o[j] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// ---------------------------------------------------------------------------
// mult_sched
// Shares one pipelined multiplier among NUM_REQ requesters. A round-robin
// arbiter picks one valid requester per cycle; its operands enter the
// multiplier while a tag pipeline (valid + requester id) travels alongside.
// A stalled output freezes the whole pipeline and blocks new grants.
// Optional feature: define MULT_SCHED_PRIO_EN to add prio_i; requesters
// with prio_i set are arbitrated first, others only when none of them is
// valid.
// Ports:
//   clk_i        clock, rising edge
//   reset_an_i   synchronous active-low reset
//   req_valid_i  per-requester operand valid
//   req_ready_o  per-requester accept, one-hot or zero
//   req_a_i      packed A operands, requester k at slice k
//   req_b_i      packed B operands, requester k at slice k
//   prio_i       (MULT_SCHED_PRIO_EN only) per-requester priority
//   res_valid_o  product valid
//   res_ready_i  downstream accepts product
//   res_id_o     requester index of product (0 when not valid)
//   res_p_o      unsigned product (0 when not valid)
//   busy_o       an accepted operation has not yet been delivered
// ---------------------------------------------------------------------------
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int A_WIDTH = 10,
    parameter int B_WIDTH = 10,
    localparam int ID_W   = id_width(NUM_REQ),
    localparam int P_W    = A_WIDTH + B_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       reset_an_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b_i,
`ifdef MULT_SCHED_PRIO_EN
    input  logic [NUM_REQ-1:0]         prio_i,
`endif
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [ID_W-1:0]            res_id_o,
    output logic [P_W-1:0]             res_p_o,
    output logic                       busy_o
);

    localparam int LAT = mult_latency(A_WIDTH, B_WIDTH);

    logic               w_stall;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_arb_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W-1:0]    w_ptr_next;
    logic [A_WIDTH-1:0] w_a;
    logic [B_WIDTH-1:0] w_b;
    logic [P_W-1:0]     w_prod;
    logic [ID_W-1:0]    r_ptr;
    logic               r_vld_pipe [LAT];
    logic [ID_W-1:0]    r_id_pipe  [LAT];

`ifdef MULT_SCHED_PRIO_EN
    logic [NUM_REQ-1:0] w_prio_req;
    assign w_prio_req = req_valid_i & prio_i;
    assign w_arb_req  = (|w_prio_req) ? w_prio_req : req_valid_i;
`else
    assign w_arb_req  = req_valid_i;
`endif

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (ID_W)
    ) u_arb (
        .req_i (w_arb_req),
        .ptr_i (r_ptr),
        .gnt_o (w_gnt)
    );

    assign w_stall     = res_valid_o & ~res_ready_i;
    // no grant while the output is blocked or reset is asserted
    assign req_ready_o = w_gnt & {NUM_REQ{reset_an_i & ~w_stall}};
    assign w_accept    = |(req_valid_i & req_ready_o);

    always_comb begin
        w_gnt_idx = '0;
        w_a       = '0;
        w_b       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                w_gnt_idx = ID_W'(k);
                w_a       = req_a_i[k*A_WIDTH +: A_WIDTH];
                w_b       = req_b_i[k*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // explicit wrap so non-power-of-two NUM_REQ stays in range
    assign w_ptr_next = (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + ID_W'(1);

    mult_pipe #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH),
        .LATENCY (LAT)
    ) u_mult (
        .clk_i      (clk_i),
        .reset_an_i (1'b1),
        .reset_i    (~reset_an_i),
        .stall_i    (w_stall),
        .a_i        (w_a),
        .b_i        (w_b),
        .p_o        (w_prod)
    );

    // tag pipeline control: valids and pointer
    always_ff @(posedge clk_i) begin
        if (!reset_an_i) begin
            r_ptr <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_vld_pipe[i] <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                r_ptr <= w_ptr_next;
            end
            if (!w_stall) begin
                r_vld_pipe[0] <= w_accept;
                for (int i = 1; i < LAT; i++) begin
                    r_vld_pipe[i] <= r_vld_pipe[i-1];
                end
            end
        end
    end

    // tag pipeline data: ids are qualified by the valids, so no reset
    always_ff @(posedge clk_i) begin
        if (!w_stall) begin
            r_id_pipe[0] <= w_gnt_idx;
            for (int i = 1; i < LAT; i++) begin
                r_id_pipe[i] <= r_id_pipe[i-1];
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy_o = busy_o | r_vld_pipe[i];
        end
    end

    assign res_valid_o = r_vld_pipe[LAT-1];
    assign res_id_o    = res_valid_o ? r_id_pipe[LAT-1] : '0;
    assign res_p_o     = res_valid_o ? w_prod : '0;

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier.
REQ-002 SHALL have parameter A_WIDTH, default 10, operand A width.
REQ-003 SHALL have parameter B_WIDTH, default 10, operand B width.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_an_i  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  NUM_REQ  per-requester operand valid.
REQ-007 SHALL have port req_ready_o  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 SHALL have port req_a_i  input  NUM_REQ*A_WIDTH  packed A operands, requester k at slice k.
REQ-009 SHALL have port req_b_i  input  NUM_REQ*B_WIDTH  packed B operands, requester k at slice k.
REQ-010 SHALL have port res_valid_o  output  1  product valid.
REQ-011 SHALL have port res_ready_i  input  1  downstream accepts product.
REQ-012 SHALL have port res_id_o  output  ID_W  requester index of product; ID_W = max(1, ceil(log2(NUM_REQ))).
REQ-013 SHALL have port res_p_o  output  A_WIDTH+B_WIDTH  unsigned product.
REQ-014 SHALL have port busy_o  output  1  high while any accepted operation has not yet been delivered.

Function
REQ-015 SHALL instantiate one multiplier with latency L = max(1, bit_width(min(A_WIDTH,B_WIDTH)-1)); L=4 for 10x10.
REQ-016 SHALL define stall = res_valid_o & ~res_ready_i; drive multiplier stall_i from stall.
REQ-017 SHALL assert req_ready_o[k] combinationally only when k is the round-robin winner among valid requesters and stall is low.
REQ-018 SHALL treat a request as accepted on a rising edge where req_valid_i[k] & req_ready_o[k]; its operands enter the multiplier that cycle.
REQ-019 SHALL carry a valid bit and ID through an L-deep tag pipeline advancing in lockstep with the multiplier; bubbles propagate as valid=0.
REQ-020 SHALL present res_valid_o, res_id_o, res_p_o exactly L cycles after acceptance when no stall occurs; each stalled cycle adds one cycle.
REQ-021 SHALL hold res_valid_o, res_id_o, res_p_o and all pipeline contents stable while stall is high.
REQ-022 SHALL update the round-robin pointer only on acceptance, to (granted index + 1) mod NUM_REQ; search order starts at the pointer.
REQ-023 SHALL sustain one acceptance and one delivery per cycle with continuous valid requests and res_ready_i=1.
REQ-024 SHALL never drop or duplicate a product; each acceptance yields exactly one res_valid_o & res_ready_i handshake.
REQ-025 SHALL drive res_p_o = 0 and res_id_o = 0 when res_valid_o is low.

Reset
REQ-026 SHALL, on reset_an_i low at a clock edge, clear tag pipeline valids, pointer to 0, res_valid_o=0, res_id_o=0, res_p_o=0, busy_o=0, req_ready_o=0.
REQ-027 SHALL tie multiplier reset_an_i high and drive its reset_i from ~reset_an_i, so products in flight are discarded on reset mid-operation.
REQ-028 SHALL resume arbitration from requester 0 in the first cycle after reset_an_i returns high.

Configuration
REQ-029 SHALL, with MULT_SCHED_PRIO_EN defined, add input prio_i (NUM_REQ bits); round-robin among valid requesters with prio_i set first, falling back to all valid requesters when none qualify.
REQ-030 SHALL, without MULT_SCHED_PRIO_EN, omit prio_i and use plain round-robin over all requesters.

Structure
REQ-031 SHALL place bit_width/latency function, ID_W computation and the latency constant in shared package mult_sched_pkg.
REQ-032 SHALL implement the round-robin pick (request vector, pointer -> one-hot grant) as sub-module rr_arbiter; the multiplier is reused unmodified.

Verification (NUM_REQ=4, 10x10, L=4)
REQ-033 SHALL cover: req 0 valid a=3,b=5 at cycle 0 -> req_ready_o=4'b0001 cycle 0; res_valid_o=1, id=0, p=15 at cycle 4.
REQ-034 SHALL cover: all four valid continuously, res_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles; results in same ID order at cycles 4..8.
REQ-035 SHALL cover: res_ready_i low 3 cycles with result pending -> res_* stable, req_ready_o=0, no results lost, order preserved.
REQ-036 SHALL cover: a=1023,b=1023 -> p=1046529; a=0 -> p=0.
REQ-037 SHALL cover: two operations in flight, reset_an_i low one cycle -> res_valid_o=0 next cycle, busy_o=0, no stale product afterwards, next grant requester 0.
REQ-038 SHALL cover (MULT_SCHED_PRIO_EN): all valid, prio_i=4'b1000 -> requester 3 granted every cycle; prio_i=0 -> round-robin 0,1,2,3.
